axi_byte_responder: RTL

- Byte-wide AXI4-Lite slave. It is the responder end of the uartprobe master bus: m_axi_* of uartprobe connects to s_axi_* here.
- It replaces the ad-hoc behavioural read handler in bench and SoC integration with synthesizable RTL.
- It backs a small on-chip byte memory, with independent read and write paths and a programmable read latency.

---
 rtl/axi_byte_pkg.sv | 22 ++
 rtl/axi_byte_responder_ram.sv | 26 ++
 rtl/axi_byte_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi_byte_pkg.sv
// Shared response codes, size encoding and read FSM states for the byte responder.
package axi_byte_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_BYTE   = 3'b000;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  // A decode miss outranks a bad size.
  function automatic logic [1:0] beat_resp(input logic hit, input logic [2:0] size);
    if (!hit) return RESP_DECERR;
    if (size != SIZE_BYTE) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_byte_responder_ram.sv
// Simple dual-port byte RAM: one synchronous write port, one registered read port.
module axi_byte_responder_ram #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-edge write is not visible to this read.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_byte_responder.sv
// Byte-wide AXI4-Lite responder backed by an on-chip byte RAM with programmable read latency.
module axi_byte_responder
  import axi_byte_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [7:0]  s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [7:0]  s_axi_wdata,
  input  logic        s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  r_state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    ar_resp;
  logic          r_ok;
  logic [7:0]    ram_q;
  logic          rd_en;

  logic          aw_held;
  logic          w_held;
  logic [AW-1:0] aw_idx;
  logic [1:0]    aw_resp;
  logic [7:0]    w_data;
  logic          w_strb;
  logic          commit;
  logic          ram_we;

  logic ar_hit;
  logic aw_hit;

  // BASE_ADDR is DEPTH-aligned, so a hit is an upper-bit match.
  assign ar_hit = (s_axi_araddr[31:AW] == BASE_ADDR[31:AW]);
  assign aw_hit = (s_axi_awaddr[31:AW] == BASE_ADDR[31:AW]);

  assign rd_en       = (r_state == R_WAIT) && (r_cnt == '0);
  assign s_axi_rdata = r_ok ? ram_q : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= R_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      ar_resp       <= RESP_OKAY;
      r_ok          <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            r_idx         <= s_axi_araddr[AW-1:0];
            ar_resp       <= beat_resp(ar_hit, s_axi_arsize);
            r_cnt         <= CW'(READ_LATENCY - 1);
            s_axi_arready <= 1'b0;
            r_state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= ar_resp;
            r_ok         <= (ar_resp == RESP_OKAY);
            r_state      <= R_DATA;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Commit fires exactly once: the edge after both beats are held.
  assign commit = aw_held && w_held && !s_axi_bvalid;
  assign ram_we = !reset && commit && w_strb && (aw_resp == RESP_OKAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      aw_resp       <= RESP_OKAY;
      w_data        <= 8'h00;
      w_strb        <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else if (s_axi_bvalid && s_axi_bready) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
    end else begin
      if (!aw_held) begin
        if (s_axi_awvalid && s_axi_awready) begin
          aw_idx        <= s_axi_awaddr[AW-1:0];
          aw_resp       <= beat_resp(aw_hit, s_axi_awsize);
          aw_held       <= 1'b1;
          s_axi_awready <= 1'b0;
        end else begin
          s_axi_awready <= 1'b1;
        end
      end
      if (!w_held) begin
        if (s_axi_wvalid && s_axi_wready) begin
          w_data       <= s_axi_wdata;
          w_strb       <= s_axi_wstrb;
          w_held       <= 1'b1;
          s_axi_wready <= 1'b0;
        end else begin
          s_axi_wready <= 1'b1;
        end
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_resp;
      end
    end
  end

  axi_byte_responder_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (aw_idx),
    .wdata (w_data),
    .re    (rd_en),
    .raddr (r_idx),
    .rdata (ram_q)
  );

endmodule
